cmp_search_ctrl: RTL and testbench

Sequential initiator for the team's GT/EQ/LT magnitude-compare interface. It drives the B operand of an external combinational comparator whose A operand holds an unknown secret value. It consumes the comparator's GT/EQ/LT flags and finds A by binary search. It reports the found value, the probe count, and an error if the comparator flags are inconsistent.

---
 rtl/cmp_search_pkg.sv | 22 ++
 rtl/cmp_flag_decode.sv | 24 ++
 rtl/cmp_search_ctrl.sv | 143 ++++++++++++++
 tb/tb_cmp_search_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_search_pkg.sv
// Shared types for the GT/EQ/LT binary-search initiator.
// Holds the FSM state encoding, the decoded comparator flag codes and the probe-counter width.
// Pure declarations; no logic.
package cmp_search_pkg;

  localparam int PCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    F_GT  = 2'd0,
    F_EQ  = 2'd1,
    F_LT  = 2'd2,
    F_BAD = 2'd3
  } flag_t;

endpackage

// File: rtl/cmp_flag_decode.sv
// Decodes the comparator's GT/EQ/LT flags into a single code.
// Purely combinational, zero latency.
// Anything other than exactly one flag set (000, or two or more set) maps to F_BAD.
module cmp_flag_decode
  import cmp_search_pkg::*;
(
  input  logic  in_gt,
  input  logic  in_eq,
  input  logic  in_lt,
  output flag_t code
);

  // One-hot check and decode of the three comparator flags
  always_comb begin
    code = F_BAD;
    case ({in_gt, in_eq, in_lt})
      3'b100:  code = F_GT;
      3'b010:  code = F_EQ;
      3'b001:  code = F_LT;
      default: code = F_BAD;
    endcase
  end

endmodule

// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator: drives comparator B operand (guess) and narrows [lo,hi] until EQ.
// Latency: 2 cycles per probe (SETTLE then SAMPLE); N probes -> done 2N edges after start.
// No backpressure: start is only honoured in IDLE/DONE and ignored while busy.
module cmp_search_ctrl
  import cmp_search_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [WIDTH-1:0]  guess,
  input  logic              inGT,
  input  logic              inEQ,
  input  logic              inLT,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic              err,
  output logic [WIDTH-1:0]  result,
  output logic [PCNT_W-1:0] probes
);

  localparam logic [WIDTH-1:0] MAX = '1;

  // Midpoint with one extra carry bit so lo+hi never wraps at the top of the range
  function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH:1];
  endfunction

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    guess_q, guess_d;
  logic                found_q, found_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [PCNT_W-1:0]   probes_q, probes_d;
  logic [WIDTH-1:0]    g_inc, g_dec;
  flag_t               flag;

  cmp_flag_decode u_dec (
    .in_gt (inGT),
    .in_eq (inEQ),
    .in_lt (inLT),
    .code  (flag)
  );

  assign g_inc = guess_q + WIDTH'(1);
  assign g_dec = guess_q - WIDTH'(1);

  // Next-state and datapath: start initialises, SAMPLE narrows the range or terminates
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    found_d  = found_q;
    err_d    = err_q;
    result_d = result_q;
    probes_d = probes_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = SETTLE;
          lo_d     = '0;
          hi_d     = MAX;
          guess_d  = mid('0, MAX);
          probes_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
        end
      end
      SETTLE: state_d = SAMPLE;
      SAMPLE: begin
        probes_d = probes_q + PCNT_W'(1);
        state_d  = DONE;
        case (flag)
          F_EQ: begin
            found_d  = 1'b1;
            result_d = guess_q;
          end
          F_GT: begin
            if (guess_q == hi_q) begin
              err_d = 1'b1;
            end else begin
              lo_d    = g_inc;
              guess_d = mid(g_inc, hi_q);
              state_d = SETTLE;
            end
          end
          F_LT: begin
            // guess==lo also catches guess==0, where guess-1 would wrap
            if (guess_q == lo_q) begin
              err_d = 1'b1;
            end else begin
              hi_d    = g_dec;
              guess_d = mid(lo_q, g_dec);
              state_d = SETTLE;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any search in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= MAX;
      guess_q  <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      probes_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      found_q  <= found_d;
      err_q    <= err_d;
      result_q <= result_d;
      probes_q <= probes_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done   = (state_q == DONE);
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  assign probes = probes_q;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Bench for cmp_search_ctrl: a WIDTH=2 and a WIDTH=8 instance share clock/reset; one is selected at a time.
// A timeline model plans each search up front (guess list, outcome) and predicts outputs per cycle.
// A comparator model (or forced flags) drives the GT/EQ/LT inputs from the selected instance's guess.
module tb_cmp_search_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, sel, mode;
  logic [2:0] frc;
  logic [7:0] secret;

  logic       st2, st8;
  logic [1:0] g2, r2;
  logic [7:0] g8, r8;
  logic       b2, d2, f2, e2, gt2, eq2, lt2;
  logic       b8, d8, f8, e8, gt8, eq8, lt8;
  logic [3:0] p2, p8;

  assign st2 = start & ~sel;
  assign st8 = start & sel;
  assign {gt2, eq2, lt2} = mode ? frc : {(secret > {6'b0, g2}), (secret == {6'b0, g2}), (secret < {6'b0, g2})};
  assign {gt8, eq8, lt8} = mode ? frc : {(secret > g8), (secret == g8), (secret < g8)};

  cmp_search_ctrl #(.WIDTH(2)) u2 (
    .clk(clk), .reset(reset), .start(st2), .guess(g2),
    .inGT(gt2), .inEQ(eq2), .inLT(lt2),
    .busy(b2), .done(d2), .found(f2), .err(e2), .result(r2), .probes(p2)
  );

  cmp_search_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(st8), .guess(g8),
    .inGT(gt8), .inEQ(eq8), .inLT(lt8),
    .busy(b8), .done(d8), .found(f8), .err(e8), .result(r8), .probes(p8)
  );

  logic [7:0] a_guess, a_result;
  logic       a_busy, a_done, a_found, a_err;
  logic [3:0] a_probes;
  assign a_guess  = sel ? g8 : {6'b0, g2};
  assign a_result = sel ? r8 : {6'b0, r2};
  assign a_busy   = sel ? b8 : b2;
  assign a_done   = sel ? d8 : d2;
  assign a_found  = sel ? f8 : f2;
  assign a_err    = sel ? e8 : e2;
  assign a_probes = sel ? p8 : p2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- search planner: plain binary search over integers ----------------
  int p_seq[$];
  int p_found, p_err, p_res;

  function automatic void plan(input int w, input int md, input logic [2:0] fr, input int sec);
    int lo, hi, g;
    logic [2:0] fl;
    bit fin;
    p_seq.delete();
    p_found = 0; p_err = 0; p_res = 0;
    lo = 0; hi = (1 << w) - 1; g = (lo + hi) / 2; fin = 0;
    while (!fin) begin
      p_seq.push_back(g);
      fl = md != 0 ? fr : {(sec > g), (sec == g), (sec < g)};
      fin = 1;
      if (fl == 3'b010) begin
        p_found = 1; p_res = g;
      end else if (fl == 3'b100 && g < hi) begin
        lo = g + 1; g = (lo + hi) / 2; fin = 0;
      end else if (fl == 3'b001 && g > lo) begin
        hi = g - 1; g = (lo + hi) / 2; fin = 0;
      end else begin
        p_err = 1;
      end
    end
  endfunction

  // ---------------- timeline model: m_t = edges since the edge that took start ----------------
  bit m_run = 0;
  int m_t   = 0;
  int m_seq[$];
  int m_found, m_err, m_res;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 0;
      m_t   = 0;
      m_seq.delete();
    end else if (m_run && m_t < 2 * m_seq.size()) begin
      m_t++;
    end else if (start) begin
      plan(sel ? 8 : 2, mode ? 1 : 0, frc, int'(secret));
      m_seq   = p_seq;
      m_found = p_found;
      m_err   = p_err;
      m_res   = p_res;
      m_run   = 1;
      m_t     = 0;
    end
  end

  // Per-cycle comparison of the selected instance against the model
  always @(negedge clk) begin
    int eg, eb, ed, ef, ee, er, ep, n;
    eg = 0; eb = 0; ed = 0; ef = 0; ee = 0; er = 0; ep = 0;
    if (!reset && m_run) begin
      n = m_seq.size();
      if (m_t < 2 * n) begin
        eg = m_seq[m_t / 2]; eb = 1; ep = m_t / 2;
      end else begin
        eg = m_seq[n - 1]; ed = 1; ef = m_found; ee = m_err; er = m_res; ep = n;
      end
    end
    chk("guess",  int'(a_guess),  eg);
    chk("busy",   int'(a_busy),   eb);
    chk("done",   int'(a_done),   ed);
    chk("found",  int'(a_found),  ef);
    chk("err",    int'(a_err),    ee);
    chk("result", int'(a_result), er);
    chk("probes", int'(a_probes), ep);
  end

  // One search: set comparator behaviour, pulse start, wait (bounded) for done
  task automatic run(input int sec, input int md, input logic [2:0] fr, output int edges);
    secret = 8'(sec); mode = (md != 0); frc = fr;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    edges = 0;
    while (!a_done && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    if (!a_done) chk("done_timeout", 0, 1);
  endtask

  task automatic do_reset(input logic s);
    @(negedge clk); reset = 1'b1; sel = s;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    reset = 1'b1; start = 1'b0; sel = 1'b0; mode = 1'b0; frc = 3'b000; secret = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_guess", int'(a_guess), 0);
    chk("rst_busy",  int'(a_busy), 0);
    chk("rst_done",  int'(a_done), 0);
    chk("rst_probes", int'(a_probes), 0);
    reset = 1'b0;

    // Hand-computed pins on the planner
    plan(2, 0, 3'b000, 2);
    chk("pin_a2_n", p_seq.size(), 2); chk("pin_a2_g0", p_seq[0], 1); chk("pin_a2_g1", p_seq[1], 2);
    chk("pin_a2_res", p_res, 2);
    plan(2, 0, 3'b000, 3);
    chk("pin_a3_n", p_seq.size(), 3); chk("pin_a3_g2", p_seq[2], 3);
    plan(2, 1, 3'b100, 0);
    chk("pin_gt_n", p_seq.size(), 3); chk("pin_gt_err", p_err, 1);
    plan(2, 1, 3'b001, 0);
    chk("pin_lt_n", p_seq.size(), 2); chk("pin_lt_g1", p_seq[1], 0);
    plan(8, 0, 3'b000, 255);
    chk("pin_w8_255_n", p_seq.size(), 9);

    // WIDTH=2 directed cases
    run(2, 0, 3'b000, e);
    chk("a2_edges", e, 4); chk("a2_found", int'(a_found), 1);
    chk("a2_result", int'(a_result), 2); chk("a2_probes", int'(a_probes), 2);
    run(3, 0, 3'b000, e);
    chk("a3_edges", e, 6); chk("a3_result", int'(a_result), 3); chk("a3_probes", int'(a_probes), 3);
    run(0, 0, 3'b000, e);
    chk("a0_result", int'(a_result), 0); chk("a0_probes", int'(a_probes), 2);
    chk("a0_found", int'(a_found), 1);
    run(0, 1, 3'b000, e);
    chk("f000_err", int'(a_err), 1); chk("f000_found", int'(a_found), 0); chk("f000_probes", int'(a_probes), 1);
    run(1, 1, 3'b110, e);
    chk("f110_err", int'(a_err), 1); chk("f110_result", int'(a_result), 0); chk("f110_probes", int'(a_probes), 1);
    run(0, 1, 3'b100, e);
    chk("fgt_err", int'(a_err), 1); chk("fgt_probes", int'(a_probes), 3); chk("fgt_guess", int'(a_guess), 3);
    run(0, 1, 3'b001, e);
    chk("flt_err", int'(a_err), 1); chk("flt_probes", int'(a_probes), 2); chk("flt_guess", int'(a_guess), 0);

    // start in DONE restarts and done drops at the next edge
    secret = 8'd1; mode = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("restart_done", int'(a_done), 0); chk("restart_busy", int'(a_busy), 1);
    // start pulsed while busy is ignored
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    e = 0;
    while (!a_done && e < 40) begin @(negedge clk); e++; end
    chk("busy_start_result", int'(a_result), 1);

    // start held high across several searches
    secret = 8'd3; start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // asynchronous reset during SAMPLE (t=3: second SAMPLE is reached at t=3)
    secret = 8'd3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_guess", int'(a_guess), 0); chk("arst_busy", int'(a_busy), 0);
    chk("arst_probes", int'(a_probes), 0); chk("arst_found", int'(a_found), 0);
    @(negedge clk); reset = 1'b0;

    // WIDTH=8: sweep every secret with randomized extras
    do_reset(1'b1);
    for (int a = 0; a < 256; a++) begin
      if ($urandom_range(0, 7) == 0) begin
        run(a, 1, 3'($urandom_range(0, 7)), e);
      end
      run(a, 0, 3'b000, e);
      chk("w8_found", int'(a_found), 1);
      chk("w8_result", int'(a_result), a);
      chk("w8_probes_le9", int'(a_probes <= 4'd9), 1);
      chk("w8_edges_le18", int'(e <= 18), 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    // random secrets with stray start pulses while busy
    for (int k = 0; k < 40; k++) begin
      secret = 8'($urandom_range(0, 255)); mode = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start = 1'($urandom_range(0, 1));
      @(negedge clk); start = 1'b0;
      e = 0;
      while (!a_done && e < 40) begin @(negedge clk); e++; end
      chk("w8_rand_done", int'(a_done), 1);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
